// File: rtl/mat_add_seq.sv
// Row-wise matrix-add sequencer: streams A/B row pairs into an external registered
// row adder and writes result rows back, one row per cycle, with sticky overflow capture.
module mat_add_seq #(
  parameter int ROWS   = 5,
  parameter int ROW_W  = 40,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ovf_flag,
  output logic [ADDR_W-1:0] ovf_row,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [ROW_W-1:0]  rd_data_a,
  input  logic [ROW_W-1:0]  rd_data_b,
  output logic [ROW_W-1:0]  add_m1,
  output logic [ROW_W-1:0]  add_m2,
  input  logic [ROW_W-1:0]  add_out,
  input  logic              add_ovf,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ROW_W-1:0]  wr_data
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

  state_t              state_q;
  logic                busy_q, done_q, ovf_flag_q, rd_en_q;
  logic [ADDR_W-1:0]   ovf_row_q, rd_addr_q, rd_addr_d;
  logic [ROW_W-1:0]    m1_q, m2_q;
  logic                vld_p1_q, vld_p2_q, vld_p3_q;
  logic [ADDR_W-1:0]   idx_p1_q, idx_p2_q, idx_p3_q;
  logic                last_issue, last_write;

  always_comb begin
    rd_addr_d  = rd_addr_q + 1'b1;
    last_issue = (rd_addr_q == LAST_ROW);
    last_write = vld_p3_q && (idx_p3_q == LAST_ROW);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_flag_q <= 1'b0;
      ovf_row_q  <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      m1_q       <= '0;
      m2_q       <= '0;
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      vld_p3_q   <= 1'b0;
      idx_p1_q   <= '0;
      idx_p2_q   <= '0;
      idx_p3_q   <= '0;
    end else begin
      // p1: read data returning from row memories
      vld_p1_q <= rd_en_q;
      idx_p1_q <= rd_addr_q;
      // p2: operands presented to the adder
      vld_p2_q <= vld_p1_q;
      idx_p2_q <= idx_p1_q;
      if (vld_p1_q) begin
        m1_q <= rd_data_a;
        m2_q <= rd_data_b;
      end
      // p3: adder result valid, write-back slot
      vld_p3_q <= vld_p2_q;
      idx_p3_q <= idx_p2_q;
      if (vld_p3_q && add_ovf) begin
        if (!ovf_flag_q) ovf_row_q <= idx_p3_q;
        ovf_flag_q <= 1'b1;
      end

      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q    <= RUN;
          busy_q     <= 1'b1;
          rd_en_q    <= 1'b1;
          rd_addr_q  <= '0;
          ovf_flag_q <= 1'b0;
          ovf_row_q  <= '0;
        end
        RUN: begin
          if (last_issue) begin
            rd_en_q <= 1'b0;
            state_q <= DRAIN;
          end else begin
            rd_addr_q <= rd_addr_d;
          end
        end
        DRAIN: if (last_write) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ovf_flag = ovf_flag_q;
  assign ovf_row  = ovf_row_q;
  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign add_m1   = m1_q;
  assign add_m2   = m2_q;
  assign wr_en    = vld_p3_q;
  assign wr_addr  = idx_p3_q;
  assign wr_data  = add_out;

endmodule

// File: tb/tb_mat_add_seq.sv
// Bench for mat_add_seq: behavioural row memories and a lane-wise int8 adder around the
// sequencer, with a write-back scoreboard filled when each job is launched.
module tb_mat_add_seq;
  localparam int ROWS   = 5;
  localparam int ROW_W  = 40;
  localparam int ADDR_W = 3;

  logic              clk, rst, start;
  logic              busy, done, ovf_flag, rd_en, wr_en, add_ovf;
  logic [ADDR_W-1:0] ovf_row, rd_addr, wr_addr;
  logic [ROW_W-1:0]  rd_data_a, rd_data_b, add_m1, add_m2, add_out, wr_data;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ROW_W-1:0]  data;
  } wr_t;

  wr_t               exp_q[$];
  logic [ROW_W-1:0]  mem_a[8];
  logic [ROW_W-1:0]  mem_b[8];
  logic              exp_flag;
  logic [ADDR_W-1:0] exp_row;
  int                checks = 0;
  int                failures = 0;

  mat_add_seq #(.ROWS(ROWS), .ROW_W(ROW_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .ovf_flag(ovf_flag), .ovf_row(ovf_row), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .add_m1(add_m1), .add_m2(add_m2),
    .add_out(add_out), .add_ovf(add_ovf), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [ROW_W:0] lane_add(input logic [ROW_W-1:0] a, input logic [ROW_W-1:0] b);
    logic [ROW_W-1:0] s;
    logic             o;
    logic signed [8:0] t;
    s = '0;
    o = 1'b0;
    for (int i = 0; i < ROW_W / 8; i++) begin
      t = $signed(a[8*i +: 8]) + $signed(b[8*i +: 8]);
      s[8*i +: 8] = t[7:0];
      if (t[8] != t[7]) o = 1'b1;
    end
    return {o, s};
  endfunction

  // Row memories (one-cycle read latency) and registered adder
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= mem_a[rd_addr];
      rd_data_b <= mem_b[rd_addr];
    end
    {add_ovf, add_out} <= lane_add(add_m1, add_m2);
  end

  task automatic load(input logic [ROW_W-1:0] a [ROWS], input logic [ROW_W-1:0] b [ROWS]);
    for (int r = 0; r < ROWS; r++) begin
      mem_a[r] = a[r];
      mem_b[r] = b[r];
    end
  endtask

  task automatic load_const(input logic [ROW_W-1:0] a, input logic [ROW_W-1:0] b);
    for (int r = 0; r < ROWS; r++) begin
      mem_a[r] = a;
      mem_b[r] = b;
    end
  endtask

  task automatic push_job();
    logic [ROW_W:0] s;
    exp_flag = 1'b0;
    exp_row  = '0;
    for (int r = 0; r < ROWS; r++) begin
      s = lane_add(mem_a[r], mem_b[r]);
      exp_q.push_back('{addr: ADDR_W'(r), data: s[ROW_W-1:0]});
      if (s[ROW_W] && !exp_flag) begin
        exp_flag = 1'b1;
        exp_row  = ADDR_W'(r);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, ovf_flag, rd_en, wr_en} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: busy/done/ovf/rd_en/wr_en=%b expected 00000", {busy, done, ovf_flag, rd_en, wr_en});
    end
    checks++;
    if ({rd_addr, wr_addr, ovf_row} !== '0) begin
      failures++;
      $display("FAIL reset_addr: rd=%0d wr=%0d ovf_row=%0d expected 0", rd_addr, wr_addr, ovf_row);
    end
    checks++;
    if ({add_m1, add_m2} !== '0) begin
      failures++;
      $display("FAIL reset_operands: m1=%h m2=%h expected 0", add_m1, add_m2);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, rd_en, wr_en, done} !== 4'b0) begin
      failures++;
      $display("FAIL idle_after_reset: busy/rd/wr/done=%b expected 0000", {busy, rd_en, wr_en, done});
    end
  endtask

  task automatic test_basic();
    wr_t e;
    load_const(40'h0101010101, 40'h0202020202);
    start = 1'b1;
    push_job();
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (rd_en !== (cyc <= ROWS)) begin
        failures++;
        $display("FAIL basic_rd_en C%0d: got %b expected %b", cyc, rd_en, cyc <= ROWS);
      end
      if (cyc <= ROWS) begin
        checks++;
        if (rd_addr !== ADDR_W'(cyc - 1)) begin
          failures++;
          $display("FAIL basic_rd_addr C%0d: got %0d expected %0d", cyc, rd_addr, cyc - 1);
        end
      end
      checks++;
      if (wr_en !== (cyc >= 4 && cyc <= ROWS + 3)) begin
        failures++;
        $display("FAIL basic_wr_en C%0d: got %b", cyc, wr_en);
      end
      checks++;
      if (busy !== (cyc <= ROWS + 3) || done !== (cyc == ROWS + 4)) begin
        failures++;
        $display("FAIL basic_busy_done C%0d: busy=%b done=%b", cyc, busy, done);
      end
      if (wr_en && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (wr_addr !== e.addr || wr_data !== e.data || wr_data !== 40'h0303030303) begin
          failures++;
          $display("FAIL basic_write: addr=%0d data=%h expected addr=%0d data=%h", wr_addr, wr_data, e.addr, e.data);
        end
      end
      if (cyc == ROWS + 4) begin
        checks++;
        if (ovf_flag !== 1'b0 || ovf_row !== '0) begin
          failures++;
          $display("FAIL basic_ovf: flag=%b row=%0d expected 0/0", ovf_flag, ovf_row);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL basic_missing_writes: %0d rows never written", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_overflow();
    logic [ROW_W-1:0] a [ROWS];
    logic [ROW_W-1:0] b [ROWS];
    wr_t e;
    bit seen;
    a = '{40'h1010101010, 40'h1010101010, 40'h7F7F7F7F7F, 40'h1010101010, 40'h8080808080};
    b = '{40'h0101010101, 40'h0101010101, 40'h0101010101, 40'h0101010101, 40'hFFFFFFFFFF};
    load(a, b);
    start = 1'b1;
    push_job();
    seen = 0;
    for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (wr_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL ovf_extra_write: addr=%0d", wr_addr);
        end else begin
          e = exp_q.pop_front();
          if (wr_addr !== e.addr || wr_data !== e.data) begin
            failures++;
            $display("FAIL ovf_write: addr=%0d data=%h expected addr=%0d data=%h", wr_addr, wr_data, e.addr, e.data);
          end
        end
      end
      if (done) begin
        seen = 1;
        checks++;
        if (cyc != ROWS + 4 || ovf_flag !== exp_flag || ovf_row !== exp_row || ovf_row !== 3'd2) begin
          failures++;
          $display("FAIL ovf_capture: cyc=%0d flag=%b row=%0d expected cyc=%0d flag=%b row=%0d", cyc, ovf_flag, ovf_row, ROWS + 4, exp_flag, exp_row);
        end
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL ovf_timeout: done never observed got 0 expected 1");
    end
    repeat (3) @(negedge clk);
    checks++;
    if (ovf_flag !== 1'b1 || ovf_row !== 3'd2) begin
      failures++;
      $display("FAIL ovf_hold: flag=%b row=%0d expected 1/2", ovf_flag, ovf_row);
    end
    load_const(40'h0101010101, 40'h0202020202);
    start = 1'b1;
    push_job();
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (ovf_flag !== 1'b0 || ovf_row !== '0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL ovf_clear_on_start: flag=%b row=%0d busy=%b expected 0/0/1", ovf_flag, ovf_row, busy);
    end
    for (int cyc = 2; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (wr_en && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (wr_addr !== e.addr || wr_data !== e.data) begin
          failures++;
          $display("FAIL ovf_job2_write: addr=%0d data=%h expected addr=%0d data=%h", wr_addr, wr_data, e.addr, e.data);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || ovf_flag !== 1'b0) begin
      failures++;
      $display("FAIL ovf_job2_end: pending=%0d flag=%b expected 0/0", exp_q.size(), ovf_flag);
      exp_q.delete();
    end
  endtask

  task automatic test_start_busy();
    wr_t e;
    int nwr, ndone, done_cyc;
    nwr = 0;
    ndone = 0;
    done_cyc = -1;
    load_const(40'h0505050505, 40'h0A0A0A0A0A);
    start = 1'b1;
    push_job();
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      start = (cyc == 3 || cyc == 6);
      if (wr_en) begin
        nwr++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checks++;
          if (wr_addr !== e.addr || wr_data !== e.data) begin
            failures++;
            $display("FAIL busy_write: addr=%0d data=%h expected addr=%0d data=%h", wr_addr, wr_data, e.addr, e.data);
          end
        end
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
    end
    start = 1'b0;
    checks++;
    if (nwr != ROWS || ndone != 1 || done_cyc != ROWS + 4) begin
      failures++;
      $display("FAIL start_while_busy: writes=%0d dones=%0d done_cyc=%0d expected %0d/1/%0d", nwr, ndone, done_cyc, ROWS, ROWS + 4);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midjob();
    wr_t e;
    int nwr, ndone, done_cyc;
    load_const(40'h0101010101, 40'h0101010101);
    start = 1'b1;
    push_job();
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, ovf_flag, rd_en, wr_en} !== 5'b0 || {rd_addr, wr_addr, ovf_row} !== '0 || {add_m1, add_m2} !== '0) begin
      failures++;
      $display("FAIL reset_midjob_outputs: ctrl=%b rd=%0d wr=%0d m1=%h expected all 0", {busy, done, ovf_flag, rd_en, wr_en}, rd_addr, wr_addr, add_m1);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    nwr = 0;
    ndone = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (wr_en) nwr++;
      if (done || busy) ndone++;
    end
    checks++;
    if (nwr != 0 || ndone != 0) begin
      failures++;
      $display("FAIL reset_midjob_quiet: writes=%0d busy/done cycles=%0d expected 0/0", nwr, ndone);
    end
    exp_q.delete();
    start = 1'b1;
    push_job();
    nwr = 0;
    ndone = 0;
    done_cyc = -1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (wr_en) begin
        nwr++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checks++;
          if (wr_addr !== e.addr || wr_data !== e.data) begin
            failures++;
            $display("FAIL reset_rerun_write: addr=%0d data=%h expected addr=%0d data=%h", wr_addr, wr_data, e.addr, e.data);
          end
        end
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
    end
    checks++;
    if (nwr != ROWS || ndone != 1 || done_cyc != ROWS + 4) begin
      failures++;
      $display("FAIL reset_rerun: writes=%0d dones=%0d done_cyc=%0d expected %0d/1/%0d", nwr, ndone, done_cyc, ROWS, ROWS + 4);
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [ROW_W-1:0] a [ROWS];
    logic [ROW_W-1:0] b [ROWS];
    wr_t e;
    logic j1_flag;
    logic [ADDR_W-1:0] j1_row;
    a = '{40'h7F00000000, 40'h0, 40'h0, 40'h0, 40'h0};
    b = '{40'h0100000000, 40'h0, 40'h0, 40'h0, 40'h0};
    load(a, b);
    start = 1'b1;
    push_job();
    j1_flag = exp_flag;
    j1_row  = exp_row;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      @(negedge clk);
      if (cyc == 6) begin
        load_const(40'h0203040506, 40'h0101010101);
        push_job();
      end
      if (wr_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL b2b_extra_write: addr=%0d", wr_addr);
        end else begin
          e = exp_q.pop_front();
          if (wr_addr !== e.addr || wr_data !== e.data) begin
            failures++;
            $display("FAIL b2b_write C%0d: addr=%0d data=%h expected addr=%0d data=%h", cyc, wr_addr, wr_data, e.addr, e.data);
          end
        end
      end
      if (cyc == 9) begin
        checks++;
        if (done !== 1'b1 || ovf_flag !== j1_flag || ovf_row !== j1_row) begin
          failures++;
          $display("FAIL b2b_job1_done: done=%b flag=%b row=%0d expected 1/%b/%0d", done, ovf_flag, ovf_row, j1_flag, j1_row);
        end
      end
      if (cyc == 10) begin
        checks++;
        if ({rd_en, busy, done} !== 3'b000) begin
          failures++;
          $display("FAIL b2b_idle_gap: rd_en/busy/done=%b expected 000", {rd_en, busy, done});
        end
      end
      if (cyc == 11) begin
        start = 1'b0;
        checks++;
        if (rd_en !== 1'b1 || rd_addr !== '0 || ovf_flag !== 1'b0) begin
          failures++;
          $display("FAIL b2b_job2_start: rd_en=%b rd_addr=%0d flag=%b expected 1/0/0", rd_en, rd_addr, ovf_flag);
        end
      end
      if (cyc == 19) begin
        checks++;
        if (done !== 1'b1 || ovf_flag !== exp_flag || ovf_flag !== 1'b0) begin
          failures++;
          $display("FAIL b2b_job2_done: done=%b flag=%b expected 1/0", done, ovf_flag);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_missing_writes: %0d rows never written", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_pipeline();
    wr_t e;
    int nwr;
    for (int r = 0; r < ROWS; r++) begin
      mem_a[r] = 40'(r) * 40'h0101010101;
      mem_b[r] = '0;
    end
    start = 1'b1;
    push_job();
    nwr = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (wr_en) begin
        checks++;
        if (wr_addr !== ADDR_W'(nwr) || wr_data !== 40'(nwr) * 40'h0101010101) begin
          failures++;
          $display("FAIL pipe_order: addr=%0d data=%h expected addr=%0d data=%h", wr_addr, wr_data, nwr, 40'(nwr) * 40'h0101010101);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checks++;
          if (wr_addr !== e.addr || wr_data !== e.data) begin
            failures++;
            $display("FAIL pipe_write: addr=%0d data=%h expected addr=%0d data=%h", wr_addr, wr_data, e.addr, e.data);
          end
        end
        nwr++;
      end
    end
    checks++;
    if (nwr != ROWS || exp_q.size() != 0) begin
      failures++;
      $display("FAIL pipe_count: writes=%0d pending=%0d expected %0d/0", nwr, exp_q.size(), ROWS);
      exp_q.delete();
    end
  endtask

  initial begin
    for (int r = 0; r < 8; r++) begin
      mem_a[r] = '0;
      mem_b[r] = '0;
    end
    test_reset();
    test_basic();
    @(negedge clk);
    test_overflow();
    @(negedge clk);
    test_start_busy();
    @(negedge clk);
    test_reset_midjob();
    @(negedge clk);
    test_back_to_back();
    @(negedge clk);
    test_pipeline();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
